// File: rtl/a5_1_decrypt_stream_if.sv
// Ciphertext-in / plaintext-out byte streams of the A5/1 decryptor.
// The master side is the byte source and plaintext sink; the slave side is the decryptor.
interface a5_1_decrypt_stream_if;
  logic [7:0] ct_data;
  logic       ct_valid;
  logic       ct_ready;
  logic [7:0] pt_data;
  logic       pt_valid;
  logic       pt_ready;

  modport master (
    output ct_data, ct_valid, pt_ready,
    input  ct_ready, pt_data, pt_valid
  );

  modport slave (
    input  ct_data, ct_valid, pt_ready,
    output ct_ready, pt_data, pt_valid
  );
endinterface

// File: rtl/a5_1_decrypt_stream.sv
// A5/1 stream decryptor: key/frame load, 100-cycle warm-up, then XORs the keystream
// onto each ciphertext byte, MSB first, one majority clock per bit.
module a5_1_decrypt_stream #(
  parameter int unsigned NumBytes = 65536
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [63:0]            key,
  input  logic [21:0]            frame,
  output logic                   busy,
  output logic                   done,
  a5_1_decrypt_stream_if.slave   s_if
);

  localparam int unsigned CntW = $clog2(NumBytes + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumBytes);

  typedef enum logic [2:0] {StIdle, StKeyLd, StFrmLd, StWarm, StRun, StXor, StOut} state_e;

  state_e          state_q, state_d;
  logic [18:0]     r1_q, r1_d;
  logic [21:0]     r2_q, r2_d;
  logic [22:0]     r3_q, r3_d;
  logic [63:0]     key_q, key_d;
  logic [21:0]     frame_q, frame_d;
  logic [6:0]      cyc_q, cyc_d;
  logic [CntW-1:0] byte_q, byte_d;
  logic [7:0]      data_q, data_d;
  logic            done_q, done_d;

  logic            fb1, fb2, fb3, ks, maj;
  logic [18:0]     r1_step;
  logic [21:0]     r2_step;
  logic [22:0]     r3_step;
  logic [CntW-1:0] byte_inc;

  assign fb1 = r1_q[13] ^ r1_q[16] ^ r1_q[17] ^ r1_q[18];
  assign fb2 = r2_q[20] ^ r2_q[21];
  assign fb3 = r3_q[7] ^ r3_q[20] ^ r3_q[21] ^ r3_q[22];
  assign ks  = r1_q[18] ^ r2_q[21] ^ r3_q[22];
  assign maj = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);

  // Majority-clocked next values, shared by warm-up and keystream generation.
  assign r1_step = (r1_q[8]  == maj) ? {r1_q[17:0], fb1} : r1_q;
  assign r2_step = (r2_q[10] == maj) ? {r2_q[20:0], fb2} : r2_q;
  assign r3_step = (r3_q[10] == maj) ? {r3_q[21:0], fb3} : r3_q;

  assign byte_inc = (byte_q == LastCnt) ? byte_q : byte_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    key_d   = key_q;
    frame_d = frame_q;
    cyc_d   = cyc_q;
    byte_d  = byte_q;
    data_d  = data_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StKeyLd;
          key_d   = key;
          frame_d = frame;
          r1_d    = '0;
          r2_d    = '0;
          r3_d    = '0;
          cyc_d   = '0;
          byte_d  = '0;
        end
      end
      StKeyLd: begin
        r1_d  = {r1_q[17:0], fb1 ^ key_q[63]};
        r2_d  = {r2_q[20:0], fb2 ^ key_q[63]};
        r3_d  = {r3_q[21:0], fb3 ^ key_q[63]};
        key_d = {key_q[62:0], 1'b0};
        cyc_d = cyc_q + 7'd1;
        if (cyc_q == 7'd63) begin
          cyc_d   = '0;
          state_d = StFrmLd;
        end
      end
      StFrmLd: begin
        r1_d    = {r1_q[17:0], fb1 ^ frame_q[21]};
        r2_d    = {r2_q[20:0], fb2 ^ frame_q[21]};
        r3_d    = {r3_q[21:0], fb3 ^ frame_q[21]};
        frame_d = {frame_q[20:0], 1'b0};
        cyc_d   = cyc_q + 7'd1;
        if (cyc_q == 7'd21) begin
          cyc_d   = '0;
          state_d = StWarm;
        end
      end
      StWarm: begin
        r1_d  = r1_step;
        r2_d  = r2_step;
        r3_d  = r3_step;
        cyc_d = cyc_q + 7'd1;
        if (cyc_q == 7'd99) begin
          cyc_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (s_if.ct_valid) begin
          data_d  = s_if.ct_data;
          cyc_d   = '0;
          state_d = StXor;
        end
      end
      StXor: begin
        r1_d   = r1_step;
        r2_d   = r2_step;
        r3_d   = r3_step;
        // Rotate so bit 7 is always the next ciphertext bit; after 8 steps order is restored.
        data_d = {data_q[6:0], data_q[7] ^ ks};
        cyc_d  = cyc_q + 7'd1;
        if (cyc_q == 7'd7) begin
          cyc_d   = '0;
          state_d = StOut;
        end
      end
      StOut: begin
        if (s_if.pt_ready) begin
          byte_d = byte_inc;
          if (byte_inc == LastCnt) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StRun;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      key_q   <= '0;
      frame_q <= '0;
      cyc_q   <= '0;
      byte_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      key_q   <= key_d;
      frame_q <= frame_d;
      cyc_q   <= cyc_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign s_if.ct_ready = (state_q == StRun);
  assign s_if.pt_valid = (state_q == StOut);
  assign s_if.pt_data  = data_q;

endmodule

// File: tb/tb_a5_1_decrypt_stream.sv
// Bench for the A5/1 decryptor: random bytes checked against an array-based A5/1 model,
// plus setup/latency timing, stalls, round trip, mid-session reset and ignored start.
module tb_a5_1_decrypt_stream;

  localparam int unsigned Nb = 6;
  localparam logic [21:0] DfltFrame = 22'b1101001110000110010001;
  localparam logic [63:0] Key2 = 64'h0123456789ABCDEF;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] key;
  logic [21:0] frame;
  logic        busy;
  logic        done;

  a5_1_decrypt_stream_if io ();

  a5_1_decrypt_stream #(.NumBytes(Nb)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .frame (frame),
    .busy  (busy),
    .done  (done),
    .s_if  (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int bytes_done;
  logic [7:0] ks_rec [4];

  // Reference A5/1 state, one array element per register cell.
  bit m1 [19];
  bit m2 [22];
  bit m3 [23];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void m_shift(bit do1, bit do2, bit do3, bit inb);
    bit f1, f2, f3;
    f1 = m1[13] ^ m1[16] ^ m1[17] ^ m1[18];
    f2 = m2[20] ^ m2[21];
    f3 = m3[7] ^ m3[20] ^ m3[21] ^ m3[22];
    if (do1) begin
      for (int i = 18; i > 0; i--) m1[i] = m1[i-1];
      m1[0] = f1 ^ inb;
    end
    if (do2) begin
      for (int i = 21; i > 0; i--) m2[i] = m2[i-1];
      m2[0] = f2 ^ inb;
    end
    if (do3) begin
      for (int i = 22; i > 0; i--) m3[i] = m3[i-1];
      m3[0] = f3 ^ inb;
    end
  endfunction

  function automatic void m_clock_maj();
    int votes;
    bit m;
    votes = int'(m1[8]) + int'(m2[10]) + int'(m3[10]);
    m = (votes >= 2);
    m_shift(m1[8] == m, m2[10] == m, m3[10] == m, 1'b0);
  endfunction

  function automatic void model_load(logic [63:0] k, logic [21:0] f);
    foreach (m1[i]) m1[i] = 1'b0;
    foreach (m2[i]) m2[i] = 1'b0;
    foreach (m3[i]) m3[i] = 1'b0;
    for (int i = 63; i >= 0; i--) m_shift(1'b1, 1'b1, 1'b1, k[i]);
    for (int i = 21; i >= 0; i--) m_shift(1'b1, 1'b1, 1'b1, f[i]);
    for (int i = 0; i < 100; i++) m_clock_maj();
  endfunction

  function automatic logic [7:0] model_ks_byte();
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      b[7-k] = m1[18] ^ m2[21] ^ m3[22];
      m_clock_maj();
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [63:0] k, input logic [21:0] f);
    start = 1'b1;
    key   = k;
    frame = f;
    tick();
    start = 1'b0;
    // Later changes must not affect the session.
    key   = {$urandom, $urandom};
    frame = 22'($urandom);
  endtask

  task automatic start_session(input logic [63:0] k, input logic [21:0] f);
    int c;
    pulse_start(k, f);
    c = 1;
    while (!io.ct_ready && c < 400) begin
      tick();
      c++;
    end
    check_eq("setup_latency", 64'(c), 64'(187));
    model_load(k, f);
    bytes_done = 0;
  endtask

  task automatic xfer_byte(input logic [7:0] ct, input int stall, output logic [7:0] pt);
    int c;
    logic [7:0] exp_ks;
    logic [7:0] held;
    bit ok;
    io.ct_data  = ct;
    io.ct_valid = 1'b1;
    tick();
    io.ct_valid = 1'b0;
    io.ct_data  = 8'($urandom);
    c = 1;
    while (!io.pt_valid && c < 40) begin
      tick();
      c++;
    end
    check_eq("pt_latency", 64'(c), 64'(9));
    exp_ks = model_ks_byte();
    pt = io.pt_data;
    check_eq("pt_data", 64'(pt), 64'(ct ^ exp_ks));
    held = io.pt_data;
    ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick();
      ok = ok & io.pt_valid & (io.pt_data == held) & !io.ct_ready & !done;
    end
    if (stall > 0) check_eq("stall_hold", 64'(ok), 64'(1));
    io.pt_ready = 1'b1;
    tick();
    io.pt_ready = 1'b0;
    bytes_done++;
    check_eq("done", 64'(done), 64'(bytes_done == Nb));
    if (bytes_done == Nb) check_eq("busy_after_done", 64'(busy), 64'(0));
    else                  check_eq("ct_ready_next", 64'(io.ct_ready), 64'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_pt_valid"}, 64'(io.pt_valid), 64'(0));
    check_eq({tag, "_ct_ready"}, 64'(io.ct_ready), 64'(0));
    check_eq({tag, "_done"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [7:0] pt;
    logic [63:0] rkey;
    logic [21:0] rframe;
    logic [7:0] ct;
    rst = 1'b1; start = 1'b0; key = '0; frame = '0;
    io.ct_data = '0; io.ct_valid = 1'b0; io.pt_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle_outputs("reset");
    check_eq("reset_pt_data", 64'(io.pt_data), 64'(0));

    // ct_valid outside RUN must not start a transfer.
    io.ct_valid = 1'b1;
    tick();
    tick();
    io.ct_valid = 1'b0;
    check_eq("idle_ct_ignored", 64'(busy), 64'(0));

    // All-zero key/frame: keystream is zero, plaintext equals ciphertext.
    start_session('0, '0);
    xfer_byte(8'hA5, 0, pt);
    check_eq("zero_key_a5", 64'(pt), 64'(8'hA5));
    xfer_byte(8'h3C, 0, pt);
    check_eq("zero_key_3c", 64'(pt), 64'(8'h3C));

    // Record keystream bytes, then decrypt them back to zero.
    do_reset();
    start_session(Key2, DfltFrame);
    for (int i = 0; i < 4; i++) xfer_byte(8'h00, 0, ks_rec[i]);
    do_reset();
    start_session(Key2, DfltFrame);
    for (int i = 0; i < 4; i++) begin
      xfer_byte(ks_rec[i], 0, pt);
      check_eq("round_trip", 64'(pt), 64'(0));
    end

    // Full random session with a stall and an ignored start pulse.
    do_reset();
    rkey   = {$urandom, $urandom};
    rframe = 22'($urandom);
    start_session(rkey, rframe);
    for (int i = 0; i < Nb; i++) begin
      if (i == 3) begin
        pulse_start(~rkey, ~rframe);
        check_eq("start_ignored_busy", 64'(busy), 64'(1));
        check_eq("start_ignored_ready", 64'(io.ct_ready), 64'(1));
      end
      ct = 8'($urandom_range(0, 255));
      xfer_byte(ct, (i == 1) ? 20 : $urandom_range(0, 3), pt);
    end
    tick();
    check_eq("done_one_cycle", 64'(done), 64'(0));

    // Reset during warm-up.
    pulse_start(Key2, DfltFrame);
    repeat (120) tick();
    check_eq("in_warm_busy", 64'(busy), 64'(1));
    do_reset();
    check_idle_outputs("rst_warm");

    // Reset in the middle of a byte's XOR phase.
    start_session(Key2, DfltFrame);
    io.ct_data  = 8'h00;
    io.ct_valid = 1'b1;
    tick();
    io.ct_valid = 1'b0;
    repeat (3) tick();
    do_reset();
    check_idle_outputs("rst_xor");

    start_session(Key2, DfltFrame);
    for (int i = 0; i < 4; i++) begin
      xfer_byte(8'h00, 0, pt);
      check_eq("restart_ks", 64'(pt), 64'(ks_rec[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
